// File: rtl/step_controller.sv
// Run/halt/single-step gate producing cpu_en; optional PC breakpoint under STEP_CTRL_BREAKPOINT_EN.
// Latency: a request sampled at edge k changes state/cpu_en after edge k; all outputs are registered or decoded from registers.
// Backpressure: none; requests are single-cycle pulses, and a request that does not apply in the current state is dropped.
module step_controller #(
   parameter int CNT_W = 16,
   parameter int CYC_W = 32,
   parameter int PC_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic [CNT_W-1:0] step_n,
`ifdef STEP_CTRL_BREAKPOINT_EN
   input  logic [PC_W-1:0]  pc,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic             bp_valid,
   output logic             bp_hit,
`endif
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             done,
   output logic [CNT_W-1:0] remaining,
   output logic [CYC_W-1:0] cyc_count
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             done_q, done_d;
   logic [CYC_W-1:0] cyc_q;
   logic             bp_q, bp_d;
   logic             brk;

   assign cpu_en    = (state_q == S_RUN) || (state_q == S_STEP);
   assign state     = state_q;
   assign done      = done_q;
   assign remaining = rem_q;
   assign cyc_count = cyc_q;

`ifdef STEP_CTRL_BREAKPOINT_EN
   assign brk    = cpu_en && bp_valid && (pc == bp_addr);
   assign bp_hit = bp_q;
`else
   logic [PC_W-1:0] unused_pc_w;
   assign unused_pc_w = '0;
   assign brk         = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      bp_d    = bp_q;
      case (state_q)
         S_HALT: begin
            if (halt_req) begin
               state_d = S_HALT;
            end else if (run_req) begin
               state_d = S_RUN;
               bp_d    = 1'b0;
            end else if (step_req) begin
               bp_d = 1'b0;
               // A zero-length step completes at once without enabling the core.
               if (step_n != '0) begin
                  state_d = S_STEP;
                  rem_d   = step_n;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (halt_req) begin
               state_d = S_HALT;
            end else if (brk) begin
               state_d = S_HALT;
               bp_d    = 1'b1;
            end
         end
         S_STEP: begin
            if (halt_req) begin
               state_d = S_HALT;
               rem_d   = '0;
            end else if (brk) begin
               state_d = S_HALT;
               rem_d   = '0;
               bp_d    = 1'b1;
            end else if (run_req) begin
               state_d = S_RUN;
               rem_d   = '0;
               bp_d    = 1'b0;
            end else if (rem_q == CNT_W'(1)) begin
               state_d = S_HALT;
               rem_d   = '0;
               done_d  = 1'b1;
            end else begin
               rem_d = rem_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_HALT;
            rem_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_HALT;
         rem_q   <= '0;
         done_q  <= 1'b0;
         bp_q    <= 1'b0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         bp_q    <= bp_d;
         if (cpu_en) begin
            cyc_q <= cyc_q + CYC_W'(1);
         end
      end
   end

endmodule
